// File: rtl/vend_controller.sv
// vend_controller: vending machine transaction controller.
// Owns the customer credit, registers coin strobes, sequences purchase,
// the dispense handshake and change payout, and shows credit as BCD digits.
module vend_controller #(
  parameter int unsigned PRICE_0    = 15,
  parameter int unsigned PRICE_1    = 20,
  parameter int unsigned PRICE_2    = 25,
  parameter int unsigned PRICE_3    = 40,
  parameter int unsigned MAX_CREDIT = 9995
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] money,
  input  logic       put_money,
  input  logic [1:0] select,
  input  logic       buy,
  input  logic       cancel,
  output logic       dispense_valid,
  output logic [1:0] dispense_item,
  input  logic       dispense_ack,
  output logic       change_valid,
  output logic [2:0] change_coin,
  input  logic       change_ack,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       busy,
  output logic [3:0] money_0,
  output logic [3:0] money_1,
  output logic [3:0] money_2,
  output logic [3:0] money_3
);

  localparam int unsigned CW  = 14;
  localparam int unsigned BW  = 16;
  localparam int unsigned DDW = CW + BW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_DISPENSE,
    ST_CHANGE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic            put_q;
  logic            coin_ev;
  logic [CW-1:0]   coin_val;
  logic [CW:0]     coin_sum;
  logic [CW-1:0]   price;
  logic [CW-1:0]   change_val;
  logic [1:0]      item_d;
  logic            reject_d;
  logic            insuff_d;
  logic [2:0]      change_coin_d;
  logic [BW-1:0]   bcd;

  // Credit value of a coin code; zero marks an invalid code.
  function automatic logic [CW-1:0] coin_value(input logic [2:0] code);
    logic [CW-1:0] v;
    case (code)
      3'b001:  v = CW'(5);
      3'b010:  v = CW'(10);
      3'b011:  v = CW'(20);
      3'b100:  v = CW'(50);
      3'b101:  v = CW'(100);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Largest coin code whose value does not exceed the given credit.
  function automatic logic [2:0] change_code(input logic [CW-1:0] c);
    logic [2:0] code;
    if (c >= CW'(100))      code = 3'b101;
    else if (c >= CW'(50))  code = 3'b100;
    else if (c >= CW'(20))  code = 3'b011;
    else if (c >= CW'(10))  code = 3'b010;
    else if (c >= CW'(5))   code = 3'b001;
    else                    code = 3'b000;
    return code;
  endfunction

  // Rising edge of the coin strobe registers exactly one coin.
  assign coin_ev    = put_money && !put_q;
  assign coin_val   = coin_value(money);
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
  assign change_val = coin_value(change_code(credit_q));

  // Price of the currently selected item.
  always_comb begin
    price = CW'(PRICE_0);
    case (select)
      2'd0: price = CW'(PRICE_0);
      2'd1: price = CW'(PRICE_1);
      2'd2: price = CW'(PRICE_2);
      2'd3: price = CW'(PRICE_3);
      default: price = CW'(PRICE_0);
    endcase
  end

  // Next-state, credit and pulse logic for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = dispense_item;
    reject_d = 1'b0;
    insuff_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (cancel && (credit_q != '0)) begin
          state_d  = ST_CHANGE;
          reject_d = coin_ev;
        end else if (buy) begin
          reject_d = coin_ev;
          if (credit_q >= price) begin
            credit_d = credit_q - price;
            item_d   = select;
            state_d  = ST_DISPENSE;
          end else begin
            insuff_d = 1'b1;
          end
        end else if (coin_ev) begin
          if ((coin_val == '0) || (coin_sum > (CW+1)'(MAX_CREDIT))) begin
            reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CW-1:0];
            state_d  = ST_CREDIT;
          end
        end
      end
      ST_DISPENSE: begin
        reject_d = coin_ev;
        if (dispense_ack) begin
          state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        reject_d = coin_ev;
        if (change_ack) begin
          credit_d = credit_q - change_val;
          if (credit_q == change_val) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Change coin shown for the credit that will be held after this edge.
  always_comb begin
    change_coin_d = 3'b000;
    if (state_d == ST_CHANGE) begin
      change_coin_d = change_code(credit_d);
    end
  end

  // State, credit, coin edge detector and registered outputs.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      put_q          <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_item  <= 2'd0;
      change_valid   <= 1'b0;
      change_coin    <= 3'b000;
      coin_reject    <= 1'b0;
      insufficient   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      put_q          <= put_money;
      dispense_valid <= (state_d == ST_DISPENSE);
      dispense_item  <= item_d;
      change_valid   <= (state_d == ST_CHANGE);
      change_coin    <= change_coin_d;
      coin_reject    <= reject_d;
      insufficient   <= insuff_d;
      busy           <= (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    end
  end

  // Binary credit to four BCD digits (shift-and-add-3).
  always_comb begin
    logic [DDW-1:0] dd;
    dd = {BW'(0), credit_q};
    for (int i = 0; i < int'(CW); i++) begin
      for (int d = 0; d < 4; d++) begin
        if (dd[CW + 4*d +: 4] >= 4'd5) begin
          dd[CW + 4*d +: 4] = dd[CW + 4*d +: 4] + 4'd3;
        end
      end
      dd = {dd[DDW-2:0], 1'b0};
    end
    bcd = dd[DDW-1:CW];
  end

  assign money_0 = bcd[3:0];
  assign money_1 = bcd[7:4];
  assign money_2 = bcd[11:8];
  assign money_3 = bcd[15:12];

endmodule

// File: tb/tb_vend_controller.sv
// Testbench for vend_controller: directed vectors, corner sequences and
// randomized traffic checked against a behavioural model.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       clear;
  logic [2:0] money;
  logic       put_money;
  logic [1:0] select;
  logic       buy;
  logic       cancel;
  logic       dispense_valid;
  logic [1:0] dispense_item;
  logic       dispense_ack;
  logic       change_valid;
  logic [2:0] change_coin;
  logic       change_ack;
  logic       coin_reject;
  logic       insufficient;
  logic       busy;
  logic [3:0] money_0, money_1, money_2, money_3;

  always #5 clk = ~clk;

  vend_controller dut (
    .clk(clk), .clear(clear), .money(money), .put_money(put_money),
    .select(select), .buy(buy), .cancel(cancel),
    .dispense_valid(dispense_valid), .dispense_item(dispense_item),
    .dispense_ack(dispense_ack), .change_valid(change_valid),
    .change_coin(change_coin), .change_ack(change_ack),
    .coin_reject(coin_reject), .insufficient(insufficient), .busy(busy),
    .money_0(money_0), .money_1(money_1), .money_2(money_2), .money_3(money_3)
  );

  int checks = 0;
  int errors = 0;
  int rej_seen = 0;

  // Behavioural model: mode 0 = idle/credit, 1 = dispensing, 2 = paying change.
  int m_credit, m_mode, m_item, m_prev, m_rej, m_ins;
  int prices[4] = '{15, 20, 25, 40};
  int denoms[5] = '{100, 50, 20, 10, 5};

  function automatic int coin_val(input logic [2:0] c);
    case (c)
      3'b001: return 5;
      3'b010: return 10;
      3'b011: return 20;
      3'b100: return 50;
      3'b101: return 100;
      default: return 0;
    endcase
  endfunction

  function automatic int largest(input int c);
    for (int i = 0; i < 5; i++) if (denoms[i] <= c) return denoms[i];
    return 0;
  endfunction

  function automatic logic [2:0] code_of(input int v);
    case (v)
      5: return 3'b001;
      10: return 3'b010;
      20: return 3'b011;
      50: return 3'b100;
      100: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] bcd_of(input int c);
    return 16'(((c / 1000) % 10) * 4096 + ((c / 100) % 10) * 256 + ((c / 10) % 10) * 16 + (c % 10));
  endfunction

  function automatic int dut_credit();
    return 1000 * int'(money_3) + 100 * int'(money_2) + 10 * int'(money_1) + int'(money_0);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_mode = 0; m_item = 0; m_prev = 0; m_rej = 0; m_ins = 0;
  endtask

  task automatic model_step();
    bit ev;
    int v, p;
    if (clear) begin
      model_reset();
      return;
    end
    ev = put_money && (m_prev == 0);
    m_prev = int'(put_money);
    m_rej = 0;
    m_ins = 0;
    case (m_mode)
      0: begin
        if (cancel && m_credit > 0) begin
          m_mode = 2;
          m_rej = int'(ev);
        end else if (buy) begin
          m_rej = int'(ev);
          p = prices[select];
          if (m_credit >= p) begin
            m_credit -= p;
            m_item = int'(select);
            m_mode = 1;
          end else begin
            m_ins = 1;
          end
        end else if (ev) begin
          v = coin_val(money);
          if (v == 0 || m_credit + v > 9995) m_rej = 1;
          else m_credit += v;
        end
      end
      1: begin
        m_rej = int'(ev);
        if (dispense_ack) m_mode = (m_credit > 0) ? 2 : 0;
      end
      default: begin
        m_rej = int'(ev);
        if (change_ack) begin
          m_credit -= largest(m_credit);
          if (m_credit == 0) m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic check_model();
    cmp("dispense_valid", 32'(dispense_valid), 32'(m_mode == 1));
    cmp("change_valid", 32'(change_valid), 32'(m_mode == 2));
    cmp("change_coin", 32'(change_coin), 32'((m_mode == 2) ? code_of(largest(m_credit)) : 3'b000));
    cmp("coin_reject", 32'(coin_reject), 32'(m_rej));
    cmp("insufficient", 32'(insufficient), 32'(m_ins));
    cmp("busy", 32'(busy), 32'(m_mode != 0));
    cmp("digits", 32'({money_3, money_2, money_1, money_0}), 32'(bcd_of(m_credit)));
    if (m_mode == 1) cmp("dispense_item", 32'(dispense_item), 32'(m_item));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (coin_reject === 1'b1) rej_seen++;
    check_model();
  endtask

  task automatic idle_inputs();
    money = 3'b000; put_money = 1'b0; select = 2'd0; buy = 1'b0;
    cancel = 1'b0; dispense_ack = 1'b0; change_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clear = 1'b1;
    model_reset();
    #3;
    check_model();
    clear = 1'b0;
  endtask

  task automatic coin(input logic [2:0] code, output logic rej);
    money = code;
    put_money = 1'b1;
    cycle();
    rej = coin_reject;
    put_money = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic       put;
    logic [2:0] money;
    logic [1:0] sel;
    logic       buy;
    logic       dack;
    int         credit;
    logic       dv;
    logic [1:0] item;
    logic       ins;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic rej;

    tbl[0]  = '{1'b1, 3'b010, 2'd0, 1'b0, 1'b0, 10, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 10, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 3'b010, 2'd0, 1'b0, 1'b0, 20, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 20, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 3'b000, 2'd2, 1'b1, 1'b0, 20, 1'b0, 2'd0, 1'b1};
    tbl[5]  = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 20, 1'b0, 2'd0, 1'b0};
    tbl[6]  = '{1'b1, 3'b001, 2'd0, 1'b0, 1'b0, 25, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 25, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{1'b0, 3'b000, 2'd2, 1'b1, 1'b0, 0,  1'b1, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 0,  1'b1, 2'd2, 1'b0};
    tbl[10] = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b1, 0,  1'b0, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 0,  1'b0, 2'd0, 1'b0};

    // Reset state
    do_reset();
    cmp("rst_dv", 32'(dispense_valid), 0);
    cmp("rst_cv", 32'(change_valid), 0);
    cmp("rst_credit", 32'(dut_credit()), 0);

    // 201 five-unit coins
    rej_seen = 0;
    for (int i = 0; i < 201; i++) coin(3'b001, rej);
    cmp("t1_credit", 32'(dut_credit()), 1005);
    cmp("t1_m3", 32'(money_3), 1);
    cmp("t1_m2", 32'(money_2), 0);
    cmp("t1_m1", 32'(money_1), 0);
    cmp("t1_m0", 32'(money_0), 5);
    cmp("t1_rejects", 32'(rej_seen), 0);

    // Table-driven: insufficient buy, exact-price buy, dispense ack
    do_reset();
    for (int i = 0; i < 12; i++) begin
      put_money = tbl[i].put; money = tbl[i].money; select = tbl[i].sel;
      buy = tbl[i].buy; dispense_ack = tbl[i].dack;
      cycle();
      cmp($sformatf("tbl%0d_credit", i), 32'(dut_credit()), 32'(tbl[i].credit));
      cmp($sformatf("tbl%0d_dv", i), 32'(dispense_valid), 32'(tbl[i].dv));
      cmp($sformatf("tbl%0d_ins", i), 32'(insufficient), 32'(tbl[i].ins));
      cmp($sformatf("tbl%0d_cv", i), 32'(change_valid), 0);
      if (tbl[i].dv) cmp($sformatf("tbl%0d_item", i), 32'(dispense_item), 32'(tbl[i].item));
    end
    idle_inputs();

    // Buy item 0 from 100, then change 50/20/10/5 one per ack
    do_reset();
    coin(3'b101, rej);
    select = 2'd0; buy = 1'b1; cycle(); buy = 1'b0;
    cmp("t3_credit", 32'(dut_credit()), 85);
    cmp("t3_dv", 32'(dispense_valid), 1);
    dispense_ack = 1'b1; cycle(); dispense_ack = 1'b0;
    cmp("t3_cv", 32'(change_valid), 1);
    begin
      logic [2:0] exp_codes [4];
      exp_codes[0] = 3'b100; exp_codes[1] = 3'b011;
      exp_codes[2] = 3'b010; exp_codes[3] = 3'b001;
      for (int i = 0; i < 4; i++) begin
        cmp($sformatf("t3_coin%0d", i), 32'(change_coin), 32'(exp_codes[i]));
        change_ack = 1'b1; cycle(); change_ack = 1'b0; cycle();
      end
    end
    cmp("t3_cv_end", 32'(change_valid), 0);
    cmp("t3_busy_end", 32'(busy), 0);
    cmp("t3_digits_end", 32'({money_3, money_2, money_1, money_0}), 0);

    // Overflow boundary at 9950
    do_reset();
    for (int i = 0; i < 99; i++) coin(3'b101, rej);
    coin(3'b100, rej);
    cmp("t4_credit", 32'(dut_credit()), 9950);
    coin(3'b101, rej);
    cmp("t4_rej100", 32'(rej), 1);
    coin(3'b100, rej);
    cmp("t4_rej50", 32'(rej), 1);
    cmp("t4_credit_kept", 32'(dut_credit()), 9950);
    coin(3'b011, rej);
    cmp("t4_acc20", 32'(rej), 0);
    cmp("t4_credit20", 32'(dut_credit()), 9970);
    coin(3'b110, rej);
    cmp("t4_rej_invalid", 32'(rej), 1);
    cmp("t4_credit_final", 32'(dut_credit()), 9970);

    // Held strobe, coin during dispense, buy+cancel+coin together
    do_reset();
    money = 3'b010; put_money = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    put_money = 1'b0; cycle();
    cmp("t5_held", 32'(dut_credit()), 10);
    coin(3'b010, rej);
    select = 2'd0; buy = 1'b1; cycle(); buy = 1'b0;
    cmp("t5_disp_credit", 32'(dut_credit()), 5);
    coin(3'b001, rej);
    cmp("t5_rej_in_disp", 32'(rej), 1);
    cmp("t5_credit_in_disp", 32'(dut_credit()), 5);
    dispense_ack = 1'b1; cycle(); dispense_ack = 1'b0;
    change_ack = 1'b1; cycle(); change_ack = 1'b0;
    cmp("t5_idle", 32'(busy), 0);
    coin(3'b011, rej);
    coin(3'b010, rej);
    buy = 1'b1; cancel = 1'b1; put_money = 1'b1; money = 3'b001; select = 2'd1;
    cycle();
    idle_inputs();
    cmp("t5_combo_cv", 32'(change_valid), 1);
    cmp("t5_combo_rej", 32'(coin_reject), 1);
    cmp("t5_combo_credit", 32'(dut_credit()), 30);
    cycle();

    // Asynchronous clear in the middle of change payout
    do_reset();
    coin(3'b011, rej);
    coin(3'b010, rej);
    coin(3'b001, rej);
    cancel = 1'b1; cycle(); cancel = 1'b0;
    cmp("t6_cv", 32'(change_valid), 1);
    #1;
    clear = 1'b1;
    model_reset();
    #1;
    cmp("t6_cv_clr", 32'(change_valid), 0);
    cmp("t6_digits_clr", 32'({money_3, money_2, money_1, money_0}), 0);
    cmp("t6_busy_clr", 32'(busy), 0);
    put_money = 1'b1; money = 3'b001;
    #1;
    clear = 1'b0;
    cycle();
    put_money = 1'b0;
    cmp("t6_first_edge_coin", 32'(dut_credit()), 5);
    cmp("t6_after_busy", 32'(busy), 0);
    cycle();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      put_money    = 1'($urandom_range(0, 1));
      money        = 3'($urandom_range(0, 7));
      select       = 2'($urandom_range(0, 3));
      buy          = ($urandom_range(0, 7) == 0);
      cancel       = ($urandom_range(0, 23) == 0);
      dispense_ack = ($urandom_range(0, 3) == 0);
      change_ack   = ($urandom_range(0, 2) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
